// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared defaults for the synchronous FIFO and its stream drain.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_fifo_width        = 8;
    localparam int c_fifo_depth        = 16;
    localparam int c_almost_full_thr   = c_fifo_depth - 2;
    localparam int c_almost_empty_thr  = 2;

    typedef logic [1:0] occ_t;

    typedef struct packed {
        logic inflight;
        logic drop;
    } rd_flags_t;

    // A new read may start only if the buffer still has room once the word
    // already in flight lands and this cycle's pop frees its slot.
    function automatic logic can_issue(
        input occ_t occ,
        input logic inflight,
        input logic pop
    );
        logic [2:0] w_level;
        w_level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return (w_level < 3'd2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_buf2.sv
`default_nettype none
// ============================================================================
// Module   : stream_buf2
// Purpose  : Two-entry ping-pong buffer with push/pop/clear and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = c_fifo_width
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output occ_t             o_occ,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_entry0;
    logic [WIDTH-1:0] r_entry1;
    logic             r_head_ptr;
    logic             r_tail_ptr;
    occ_t             r_occ;

    // Clear wins over push/pop so a flush leaves the buffer strictly empty.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_entry0   <= '0;
            r_entry1   <= '0;
            r_head_ptr <= 1'b0;
            r_tail_ptr <= 1'b0;
            r_occ      <= '0;
        end else if (i_clear) begin
            r_head_ptr <= 1'b0;
            r_tail_ptr <= 1'b0;
            r_occ      <= '0;
        end else begin
            if (i_push) begin
                if (r_tail_ptr) begin
                    r_entry1 <= i_push_data;
                end else begin
                    r_entry0 <= i_push_data;
                end
                r_tail_ptr <= ~r_tail_ptr;
            end
            if (i_pop) begin
                r_head_ptr <= ~r_head_ptr;
            end
            r_occ <= r_occ + occ_t'(i_push) - occ_t'(i_pop);
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_head_ptr ? r_entry1 : r_entry0;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains a read-strobe FIFO into a valid/ready stream, with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = c_fifo_width,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_data,
    output logic             o_fifo_re,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_words,
    output logic             o_busy
);

    rd_flags_t        r_rd;
    logic [CNT_W-1:0] r_words;
    occ_t             w_occ;
    logic [WIDTH-1:0] w_head;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_re;

    assign w_valid = (w_occ != 2'd0);
    assign w_pop   = w_valid && i_ready;
    assign w_push  = r_rd.inflight && !r_rd.drop && !i_flush;
    assign w_re    = !i_rst && !i_flush && !i_fifo_empty
                     && can_issue(w_occ, r_rd.inflight, w_pop);

    stream_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (i_flush),
        .i_push      (w_push),
        .i_push_data (i_fifo_data),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    // A pop coinciding with a flush is discarded along with the buffer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd    <= '0;
            r_words <= '0;
        end else begin
            r_rd.inflight <= w_re;
            r_rd.drop     <= i_flush && r_rd.inflight;
            if (w_pop && !i_flush) begin
                r_words <= r_words + CNT_W'(1);
            end
        end
    end

    assign o_fifo_re = w_re;
    assign o_valid   = w_valid;
    assign o_data    = w_head;
    assign o_words   = r_words;
    assign o_busy    = w_valid || r_rd.inflight;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Directed self-checking bench: FIFO model feeding the drain stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       ready;
    logic       wr_en;
    logic [7:0] wr_data;

    // Behavioural 16-deep FIFO with registered read data.
    logic [7:0] f_mem [16];
    logic [3:0] f_wptr;
    logic [3:0] f_rptr;
    logic [4:0] f_count;
    logic [7:0] f_rdata;
    logic       f_underflow;
    logic       f_empty;
    logic       wr_ok;
    logic       rd_ok;
    int         n_reads;

    logic       fifo_re;
    logic       valid;
    logic [7:0] data;
    logic [15:0] words;
    logic       busy;

    logic       empty2;
    logic [7:0] din2;
    logic       flush2;
    logic       ready2;
    logic       re2;
    logic       valid2;
    logic [7:0] dout2;
    logic [3:0] words2;
    logic       busy2;

    int n_checks;
    int n_fail;
    int n;

    assign f_empty = (f_count == 5'd0);
    assign wr_ok   = wr_en && (f_count != 5'd16);
    assign rd_ok   = fifo_re && !f_empty;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f_wptr      <= '0;
            f_rptr      <= '0;
            f_count     <= '0;
            f_rdata     <= '0;
            f_underflow <= 1'b0;
            n_reads     <= 0;
        end else begin
            if (wr_ok) begin
                f_mem[f_wptr] <= wr_data;
                f_wptr        <= f_wptr + 4'd1;
            end
            if (fifo_re && f_empty) begin
                f_underflow <= 1'b1;
            end
            if (rd_ok) begin
                f_rdata <= f_mem[f_rptr];
                f_rptr  <= f_rptr + 4'd1;
                n_reads <= n_reads + 1;
            end
            f_count <= f_count + 5'(wr_ok) - 5'(rd_ok);
        end
    end

    fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fifo_empty (f_empty),
        .i_fifo_data  (f_rdata),
        .o_fifo_re    (fifo_re),
        .i_flush      (flush),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_data       (data),
        .o_words      (words),
        .o_busy       (busy)
    );

    fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) dut_w4 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fifo_empty (empty2),
        .i_fifo_data  (din2),
        .o_fifo_re    (re2),
        .i_flush      (flush2),
        .o_valid      (valid2),
        .i_ready      (ready2),
        .o_data       (dout2),
        .o_words      (words2),
        .o_busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        ready = 1'b0;
        flush = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Loads 16 words while flush holds off reads; returns on a negedge.
    task automatic fill(input logic [7:0] base);
        flush = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(k);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        ready    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        empty2   = 1'b1;
        din2     = 8'hA5;
        flush2   = 1'b0;
        ready2   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data",  data,  0);
        check("rst_words", words, 0);
        check("rst_busy",  busy,  0);
        check("rst_re",    fifo_re, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single word, 2-cycle latency
        ready   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h24;
        @(negedge clk);
        wr_en = 1'b0;
        check("t1_re_E",     fifo_re, 1);
        check("t1_valid_E",  valid, 0);
        @(negedge clk);
        check("t1_valid_E1", valid, 0);
        check("t1_busy_E1",  busy, 1);
        @(negedge clk);
        check("t1_valid_E2", valid, 1);
        check("t1_data_E2",  data, 8'h24);
        @(negedge clk);
        check("t1_valid_E3", valid, 0);
        check("t1_words",    words, 1);
        check("t1_busy",     busy, 0);
        check("t1_underflow", f_underflow, 0);

        // Full-throughput drain of 16 words
        do_reset();
        fill(8'h40);
        flush = 1'b0;
        ready = 1'b1;
        #1;
        check("t2_re_start", fifo_re, 1);
        @(negedge clk);
        check("t2_valid_P1", valid, 0);
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            check("t2_valid", valid, 1);
            check("t2_data",  data, 8'h40 + 8'(k));
            if (k <= 13) check("t2_re_steady", fifo_re, 1);
            @(negedge clk);
        end
        check("t2_valid_end", valid, 0);
        check("t2_words",     words, 16);
        check("t2_busy",      busy, 0);
        check("t2_fifo_cnt",  f_count, 0);

        // Backpressure for 10 cycles, then release
        do_reset();
        fill(8'h60);
        flush = 1'b0;
        ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 1) check("t3_hold_data", data, 8'h60);
        end
        check("t3_reads",    n_reads, 2);
        check("t3_fifo_cnt", f_count, 14);
        check("t3_valid",    valid, 1);
        ready = 1'b1;
        #1;
        check("t3_re_on_ready", fifo_re, 1);
        for (int k = 0; k < 16; k++) begin
            check("t3_valid_drain", valid, 1);
            check("t3_data_drain",  data, 8'h60 + 8'(k));
            @(negedge clk);
        end
        check("t3_valid_end", valid, 0);
        check("t3_words",     words, 16);

        // Flush with a word in flight and a simultaneous pop
        do_reset();
        fill(8'h80);
        flush = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_occ2_data", data, 8'h80);
        ready = 1'b1;
        #1;
        check("t4_re_pop", fifo_re, 1);
        @(negedge clk);
        check("t4_words_pre", words, 1);
        check("t4_data_pre",  data, 8'h81);
        flush = 1'b1;
        #1;
        check("t4_re_flush", fifo_re, 0);
        @(negedge clk);
        flush = 1'b0;
        check("t4_valid_F",  valid, 0);
        check("t4_words_F",  words, 1);
        check("t4_busy_F",   busy, 0);
        check("t4_fifo_cnt", f_count, 13);
        @(negedge clk);
        check("t4_valid_F1", valid, 0);
        @(negedge clk);
        check("t4_valid_F2", valid, 1);
        check("t4_data_F2",  data, 8'h83);
        @(negedge clk);
        check("t4_words_F3", words, 2);
        check("t4_data_F3",  data, 8'h84);

        // Asynchronous reset mid-stream
        do_reset();
        fill(8'hC0);
        flush = 1'b0;
        ready = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_words_mid", words, 8);
        check("t5_data_mid",  data, 8'hC8);
        #2;
        rst = 1'b1;
        #1;
        check("t5_arst_valid", valid, 0);
        check("t5_arst_data",  data, 0);
        check("t5_arst_words", words, 0);
        check("t5_arst_busy",  busy, 0);
        check("t5_arst_re",    fifo_re, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_post_valid", valid, 0);
        check("t5_post_re",    fifo_re, 0);
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_resume_valid", valid, 1);
        check("t5_resume_data",  data, 8'h5A);
        @(negedge clk);
        check("t5_resume_words", words, 1);

        // 4-bit counter wrap after 17 deliveries
        check("t6_words_init", words2, 0);
        empty2 = 1'b0;
        ready2 = 1'b1;
        n      = 0;
        for (int k = 0; k < 60 && n < 17; k++) begin
            @(negedge clk);
            if (valid2) n++;
        end
        @(posedge clk);
        #1;
        ready2 = 1'b0;
        empty2 = 1'b1;
        @(negedge clk);
        check("t6_pop_count", n, 17);
        check("t6_words_wrap", words2, 1);
        check("t6_data", dout2, 8'hA5);

        check("underflow_never", f_underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
